// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bus bundle for the data-memory arbiter.
//   cpu_*  : MEM-stage access (rd/wr/addr/wdata/func3 in, rdata/stall out)
//   dbg_*  : debug/loader req/ack port (req/we/addr/wdata/func3 in,
//            ack/rdata out)
//   mem_*  : single-port datamemory side (rd/wr/addr/wdata/func3 out,
//            rdata in)
// Modports:
//   slave  : the arbiter's view.
//   master : the surrounding pipeline / requester / memory view.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  cpu_rd;
    logic                  cpu_wr;
    logic [DM_ADDRESS-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [2:0]            cpu_func3;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_stall;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic [2:0]            dbg_func3;
    logic                  dbg_ack;
    logic [DATA_W-1:0]     dbg_rdata;

    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_func3;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_func3,
        output dbg_ack, dbg_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_func3,
        input  dbg_ack, dbg_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the MEM stage (combinational
// pass-through, stalled when refused) and a debug/loader requester (req/ack).
// The CPU wins contended cycles until a pending debug request has waited
// STARVE_LIM of them; the debug access then goes through, followed by one ACK
// cycle in which the CPU always owns the memory.
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   bus            : dmem_arbiter_if.slave (cpu_*, dbg_*, mem_* groups)
//   perf_conflicts : 16-bit saturating contended-cycle count
//                    (only when DMEM_ARB_PERF_EN is defined)
// Optional feature macro: DMEM_ARB_PERF_EN
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]    perf_conflicts
`endif
);
    localparam int               CNT_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CNT_W-1:0] LIM    = CNT_W'(STARVE_LIM);
    localparam logic [0:0]       S_IDLE = 1'b0;
    localparam logic [0:0]       S_ACK  = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      starve_cnt;
    logic [DATA_W-1:0]     dbg_rdata_q;
    logic [DM_ADDRESS-1:0] addr_sel;
    logic                  cpu_req;
    logic                  contended;
    logic                  dbg_win;

    assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
    // Only IDLE cycles arbitrate; the ACK cycle belongs to the CPU.
    assign contended = (state == S_IDLE) & cpu_req & bus.dbg_req;
    assign dbg_win   = (state == S_IDLE) & bus.dbg_req & (~cpu_req | (starve_cnt == LIM));

    assign addr_sel  = dbg_win ? bus.dbg_addr : bus.cpu_addr;

    // Enables are gated by reset directly so nothing is written on an edge
    // while reset is held, even though the muxes are purely combinational.
    always_comb begin
        bus.mem_addr  = addr_sel;
        bus.mem_wdata = dbg_win ? bus.dbg_wdata : bus.cpu_wdata;
        bus.mem_func3 = dbg_win ? bus.dbg_func3 : bus.cpu_func3;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.cpu_stall = 1'b0;
        if (reset) begin
            bus.mem_rd    = dbg_win ? ~bus.dbg_we : bus.cpu_rd;
            bus.mem_wr    = dbg_win ?  bus.dbg_we : bus.cpu_wr;
            bus.cpu_stall = dbg_win & cpu_req;
        end
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dbg_ack   = (state == S_ACK);
    assign bus.dbg_rdata = dbg_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            dbg_rdata_q <= '0;
        end else if (dbg_win) begin
            state      <= S_ACK;
            starve_cnt <= '0;
            if (!bus.dbg_we)
                dbg_rdata_q <= bus.mem_rdata;
        end else begin
            state <= S_IDLE;
            // starve_cnt is frozen in ACK; it restarts counting in IDLE.
            if (state == S_IDLE) begin
                if (contended) begin
                    if (starve_cnt != LIM)
                        starve_cnt <= starve_cnt + 1'b1;
                end else if (!bus.dbg_req) begin
                    starve_cnt <= '0;
                end
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Counts every contended IDLE cycle, including the one the debug side wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_conflicts <= '0;
        else if (contended && perf_conflicts != 16'hFFFF)
            perf_conflicts <= perf_conflicts + 16'd1;
    end
`endif
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter in front of the single-port data memory. Shares the memory between the pipeline MEM stage (CPU port, same-cycle pass-through) and a debug/loader requester (DBG port, req/ack handshake). It uses a bounded-starvation policy, so neither side can be locked out. It sits between the EX/MEM pipeline register and `datamemory`; `cpu_stall` is OR-ed into the pipeline stall so the EX/MEM contents are held while the CPU is refused.

## Interface
Parameters:
- `DM_ADDRESS`, 9: data memory address width.
- `DATA_W`, 32: data width.
- `STARVE_LIM`, 4: number of consecutive contended cycles the CPU may win before a pending DBG request is forced through. 0 gives DBG strict priority.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpu_rd` input 1: MEM-stage read enable.
- `cpu_wr` input 1: MEM-stage write enable.
- `cpu_addr` input DM_ADDRESS: MEM-stage address.
- `cpu_wdata` input DATA_W: MEM-stage store data.
- `cpu_func3` input 3: access size/sign code.
- `cpu_rdata` output DATA_W: load data, equal to `mem_rdata`.
- `cpu_stall` output 1: CPU request refused this cycle; the pipeline must hold.
- `dbg_req` input 1: debug request, level-held until `dbg_ack`.
- `dbg_we` input 1: 1 = write, 0 = read.
- `dbg_addr` input DM_ADDRESS: debug address.
- `dbg_wdata` input DATA_W: debug write data.
- `dbg_func3` input 3: debug access size code.
- `dbg_ack` output 1: one-cycle completion pulse.
- `dbg_rdata` output DATA_W: registered read data for the debug port.
- `mem_rd` output 1: read enable to `datamemory`.
- `mem_wr` output 1: write enable to `datamemory`.
- `mem_addr` output DM_ADDRESS: address to `datamemory`.
- `mem_wdata` output DATA_W: write data to `datamemory`.
- `mem_func3` output 3: size code to `datamemory`.
- `mem_rdata` input DATA_W: combinational read data from `datamemory`.
- `perf_conflicts` output 16: contended-cycle count. Present only with `DMEM_ARB_PERF_EN`.

## Operation
Definitions:
- `cpu_req` = `cpu_rd` | `cpu_wr`.
- Arbitration state is two-state: IDLE and ACK.
- `starve_cnt` is a register wide enough to hold `STARVE_LIM`.

IDLE:
- `dbg_win` = `dbg_req` & (!`cpu_req` | `starve_cnt` == `STARVE_LIM`).
- When `dbg_win` = 1:
  - `mem_*` is driven from the `dbg_*` fields: `mem_wr` = `dbg_we`, `mem_rd` = !`dbg_we`.
  - `cpu_stall` = `cpu_req`.
  - `starve_cnt` is cleared to 0.
  - For a read, `dbg_rdata` is loaded with `mem_rdata` at the clock edge.
  - Next state is ACK.
- Otherwise:
  - `mem_*` is driven from the `cpu_*` fields.
  - `cpu_stall` = 0.
  - If `cpu_req` & `dbg_req`, `starve_cnt` increments, saturating at `STARVE_LIM`.
  - If `dbg_req` = 0, `starve_cnt` is cleared to 0.

ACK:
- `dbg_ack` = 1.
- The CPU owns the memory unconditionally, with `cpu_stall` = 0. This guarantees CPU forward progress between consecutive DBG accesses.
- `dbg_req` is ignored in this cycle.
- Next state is IDLE.

Debug port rules:
- The requester holds all `dbg_*` fields stable from raising `dbg_req` until it sees `dbg_ack`.
- Keeping `dbg_req` high after `dbg_ack`, with new fields, starts the next transaction in the following IDLE cycle.
- On a debug write, `dbg_rdata` holds its previous value.

Other rules:
- When no port drives the memory, `mem_rd` = `mem_wr` = 0 and `mem_addr`/`mem_wdata`/`mem_func3` follow the CPU fields.
- `cpu_rdata` = `mem_rdata` at all times. It is valid only when `cpu_rd` & !`cpu_stall`.

## Timing
- CPU access latency is 0 added cycles when uncontested: a combinational pass-through, identical to a direct memory hookup.
- Each DBG win costs the CPU exactly one stall cycle, and only if `cpu_req` was set.
- DBG latency is measured from the first cycle of `dbg_req` in IDLE to `dbg_ack`:
  - Uncontested: 1 cycle.
  - Worst case: `STARVE_LIM` + 1 cycles.
- `dbg_rdata` is valid in the `dbg_ack` cycle and holds until the next DBG read completes.
- While `reset` = 0, asynchronously and immediately:
  - State goes to IDLE, `starve_cnt` = 0, `dbg_ack` = 0, `dbg_rdata` = 0, `perf_conflicts` = 0.
  - `mem_rd`, `mem_wr` and `cpu_stall` are forced to 0, so no write happens on an edge during reset.
- A transaction in flight when reset asserts is abandoned with no ack. The requester must reissue it after reset deasserts.

## Configuration
- `DMEM_ARB_PERF_EN` defined:
  - `perf_conflicts` port and a 16-bit counter exist.
  - The counter increments on each IDLE cycle with `cpu_req` & `dbg_req`, and saturates at 16'hFFFF.
- `DMEM_ARB_PERF_EN` undefined:
  - The port and counter are absent.
  - Arbitration behaviour is identical.

## Test plan
- Reset: drive `reset` = 0 mid-ACK -> `dbg_ack`, `mem_wr`, `cpu_stall` and `dbg_rdata` go to 0 immediately; after release, the state is IDLE.
- CPU only: `cpu_wr` = 1, `cpu_addr` = 9'h010, `cpu_wdata` = 32'hDEADBEEF; then `cpu_rd` of the same address -> `cpu_stall` = 0 throughout and `cpu_rdata` = 32'hDEADBEEF.
- DBG only: `dbg_we` = 1, `dbg_addr` = 9'h020, `dbg_wdata` = 32'h12345678 -> `dbg_ack` in the next cycle. A following DBG read of the same address -> `dbg_rdata` = 32'h12345678 with `dbg_ack`.
- Contention, `STARVE_LIM` = 4: `cpu_rd` held continuously and `dbg_req` raised at cycle 0 -> CPU wins cycles 0-3; DBG wins cycle 4 with `cpu_stall` = 1; `dbg_ack` at cycle 5 with CPU served.
- Back-to-back DBG: `dbg_req` held across two transactions while `cpu_req` = 1 -> DBG never wins two consecutive cycles; an ACK cycle always separates the wins.
- With `DMEM_ARB_PERF_EN`: the contention scenario -> `perf_conflicts` = 5 after the DBG win. Preload the counter path to 16'hFFFF plus one contended cycle -> the count stays at 16'hFFFF.
